// File: rtl/sr_bank_if.sv
// Bus bundle for sr_bank: control/request inputs and registered channel outputs.
// There is no valid/ready handshake here: e qualifies s/r each clock, and clr
// acts on every rising edge regardless of e.
interface sr_bank_if #(
    parameter int N  = 8,
    parameter int CW = 8
);
    logic          e;
    logic [N-1:0]  s;
    logic [N-1:0]  r;
    logic          clr;
    logic [N-1:0]  q;
    logic [N-1:0]  qn;
    logic [N-1:0]  conf;
    logic          err;
    logic [CW-1:0] cnt;

    modport master (output e, s, r, clr, input q, qn, conf, err, cnt);
    modport slave  (input e, s, r, clr, output q, qn, conf, err, cnt);
endinterface

// File: rtl/sr_bank.sv
// sr_bank: N independent set/reset channels with conflict flags, a sticky
// error bit and a saturating conflict counter.
// Optional feature macro SR_BANK_TOGGLE_EN: s=r=1 toggles the channel (JK
// behaviour) and is not treated as a conflict.
module sr_bank #(
    parameter int           N    = 8,
    parameter int           PRIO = 0,
    parameter logic [N-1:0] INIT = {N{1'b0}},
    parameter int           CW   = 8
) (
    input logic      clk,
    input logic      rst,
    sr_bank_if.slave bus
);
    // Out-of-range priority codes fall back to reset-dominant.
    localparam int EFF_PRIO = (PRIO == 1 || PRIO == 2) ? PRIO : 0;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [N-1:0]  q_reg;
    logic [N-1:0]  conf_reg;
    logic          err_reg;
    logic [CW-1:0] cnt_reg;

    logic [N-1:0]  q_next;
    logic [N-1:0]  conf_next;
    logic          conflict;

    // Per-channel next state from the set/reset pair.
    always_comb begin
        q_next = q_reg;
        for (int i = 0; i < N; i++) begin
            case ({bus.s[i], bus.r[i]})
                2'b10:   q_next[i] = 1'b1;
                2'b01:   q_next[i] = 1'b0;
                2'b11: begin
`ifdef SR_BANK_TOGGLE_EN
                    q_next[i] = ~q_reg[i];
`else
                    if (EFF_PRIO == 1)
                        q_next[i] = 1'b1;
                    else if (EFF_PRIO == 2)
                        q_next[i] = q_reg[i];
                    else
                        q_next[i] = 1'b0;
`endif
                end
                default: q_next[i] = q_reg[i];
            endcase
        end
    end

    // Conflict detection; with toggling enabled s=r=1 is legal, not a conflict.
    always_comb begin
`ifdef SR_BANK_TOGGLE_EN
        conf_next = '0;
`else
        conf_next = bus.s & bus.r;
`endif
        conflict = bus.e && (conf_next != '0);
    end

    // Channel state and conflict flags advance only on enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg    <= INIT;
            conf_reg <= '0;
        end else if (bus.e) begin
            q_reg    <= q_next;
            conf_reg <= conf_next;
        end
    end

    // Sticky error and saturating counter; clr wins over a same-cycle conflict
    // and also acts while e=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (bus.clr) begin
            err_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (conflict) begin
            err_reg <= 1'b1;
            if (cnt_reg != CNT_MAX)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bus.q    = q_reg;
    assign bus.qn   = ~q_reg;
    assign bus.conf = conf_reg;
    assign bus.err  = err_reg;
    assign bus.cnt  = cnt_reg;
endmodule

// File: tb/tb_sr_bank.sv
// Testbench for sr_bank: four configurations share one stimulus stream and are
// compared against a behavioural per-channel model.
module tb_sr_bank;
    localparam int ND = 4;
    localparam int NS   [ND] = '{8, 8, 5, 8};
    localparam int PR   [ND] = '{0, 1, 2, 3};
    localparam int CWS  [ND] = '{8, 8, 2, 3};
    localparam logic [31:0] INITS [ND] = '{32'hA5, 32'h00, 32'h13, 32'h00};
    localparam int EW = 97;

`ifdef SR_BANK_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    logic clk;
    logic rst;

    sr_bank_if #(.N(8), .CW(8)) if0 ();
    sr_bank_if #(.N(8), .CW(8)) if1 ();
    sr_bank_if #(.N(5), .CW(2)) if2 ();
    sr_bank_if #(.N(8), .CW(3)) if3 ();

    sr_bank #(.N(8), .PRIO(0), .INIT(8'hA5), .CW(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    sr_bank #(.N(8), .PRIO(1), .INIT(8'h00), .CW(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    sr_bank #(.N(5), .PRIO(2), .INIT(5'h13), .CW(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    sr_bank #(.N(8), .PRIO(3), .INIT(8'h00), .CW(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];

    logic [31:0] m_q    [ND];
    logic [31:0] m_conf [ND];
    logic        m_err  [ND];
    logic [31:0] m_cnt  [ND];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mask_of(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_q[d]    = INITS[d];
            m_conf[d] = '0;
            m_err[d]  = 1'b0;
            m_cnt[d]  = '0;
        end
    endtask

    task automatic model_step(input int d, input bit e, input logic [31:0] s,
                              input logic [31:0] r, input bit clr);
        logic [31:0] msk;
        logic [31:0] nq;
        logic [31:0] nconf;
        int          prio;
        int          maxc;
        msk  = mask_of(NS[d]);
        prio = (PR[d] == 1 || PR[d] == 2) ? PR[d] : 0;
        maxc = (1 << CWS[d]) - 1;
        nq    = m_q[d];
        nconf = '0;
        if (e) begin
            for (int i = 0; i < NS[d]; i++) begin
                if (s[i] && r[i]) begin
                    if (TOG)            nq[i] = ~m_q[d][i];
                    else if (prio == 1) nq[i] = 1'b1;
                    else if (prio == 0) nq[i] = 1'b0;
                    if (!TOG)           nconf[i] = 1'b1;
                end else if (s[i]) begin
                    nq[i] = 1'b1;
                end else if (r[i]) begin
                    nq[i] = 1'b0;
                end
            end
        end
        if (clr) begin
            m_err[d] = 1'b0;
            m_cnt[d] = 0;
        end else if (e && nconf != 0) begin
            m_err[d] = 1'b1;
            if (m_cnt[d] < maxc) m_cnt[d] = m_cnt[d] + 1;
        end
        if (e) begin
            m_q[d]    = nq & msk;
            m_conf[d] = nconf & msk;
        end
    endtask

    function automatic logic [EW-1:0] pack_exp(input int d);
        return {m_q[d], m_conf[d], m_err[d], m_cnt[d]};
    endfunction

    // ---------------- DUT observation ----------------
    task automatic get_obs(input int d, output logic [31:0] q, output logic [31:0] qn,
                           output logic [31:0] conf, output logic err, output logic [31:0] cnt);
        q = '0; qn = '0; conf = '0; err = 1'b0; cnt = '0;
        case (d)
            0: begin q = 32'(if0.q); qn = 32'(if0.qn); conf = 32'(if0.conf); err = if0.err; cnt = 32'(if0.cnt); end
            1: begin q = 32'(if1.q); qn = 32'(if1.qn); conf = 32'(if1.conf); err = if1.err; cnt = 32'(if1.cnt); end
            2: begin q = 32'(if2.q); qn = 32'(if2.qn); conf = 32'(if2.conf); err = if2.err; cnt = 32'(if2.cnt); end
            default: begin q = 32'(if3.q); qn = 32'(if3.qn); conf = 32'(if3.conf); err = if3.err; cnt = 32'(if3.cnt); end
        endcase
    endtask

    task automatic check_dut(input int d, input logic [EW-1:0] ex, input string ph);
        logic [31:0] q, qn, conf, cnt;
        logic        err;
        get_obs(d, q, qn, conf, err, cnt);
        check($sformatf("%s d%0d q", ph, d),    q,    ex[96:65]);
        check($sformatf("%s d%0d qn", ph, d),   qn,   ~ex[96:65] & mask_of(NS[d]));
        check($sformatf("%s d%0d conf", ph, d), conf, ex[64:33]);
        check($sformatf("%s d%0d err", ph, d),  {31'd0, err}, {31'd0, ex[32]});
        check($sformatf("%s d%0d cnt", ph, d),  cnt,  ex[31:0]);
    endtask

    // Compare every DUT against the model as it stands right now.
    task automatic check_now(input string ph);
        for (int d = 0; d < ND; d++) check_dut(d, pack_exp(d), ph);
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input bit e, input logic [31:0] s, input logic [31:0] r, input bit clr);
        if0.e = e; if0.s = s[7:0]; if0.r = r[7:0]; if0.clr = clr;
        if1.e = e; if1.s = s[7:0]; if1.r = r[7:0]; if1.clr = clr;
        if2.e = e; if2.s = s[4:0]; if2.r = r[4:0]; if2.clr = clr;
        if3.e = e; if3.s = s[7:0]; if3.r = r[7:0]; if3.clr = clr;
    endtask

    // One clocked transaction: drive, predict, clock, then compare at negedge.
    task automatic cycle(input bit e, input logic [31:0] s, input logic [31:0] r,
                         input bit clr, input string ph);
        drive(e, s, r, clr);
        for (int d = 0; d < ND; d++) begin
            model_step(d, e, s, r, clr);
            exp_q.push_back(pack_exp(d));
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            if (exp_q.size() == 0) begin
                check("scoreboard underflow", 32'd0, 32'd1);
            end else begin
                check_dut(d, exp_q.pop_front(), ph);
            end
        end
    endtask

    task automatic random_cycle(input bit no_conf, input string ph);
        logic [31:0] s, r;
        bit          e, clr;
        s   = $urandom;
        r   = $urandom;
        if (no_conf) r = r & ~s;
        e   = ($urandom_range(0, 7) != 0);
        clr = ($urandom_range(0, 19) == 0);
        cycle(e, s, r, clr, ph);
    endtask

    // Asynchronous reset pulse in the middle of a clock low phase, with a
    // conflicting request on the bus the whole time.
    task automatic mid_reset();
        drive(1'b1, 32'hFF, 32'hFF, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_now("rst_async");
        @(posedge clk);
        drive(1'b1, $urandom, $urandom, 1'b0);
        @(negedge clk);
        check_now("rst_held");
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        model_reset();
        #2;
        check_now("reset0");
        @(negedge clk);
        rst = 1'b0;

        // Clear all channels, then set/reset split.
        cycle(1'b1, 32'h00, 32'hFF, 1'b0, "zero");
        cycle(1'b1, 32'h0F, 32'hF0, 1'b0, "split");
        cycle(1'b0, 32'hFF, 32'h00, 1'b0, "freeze");
        cycle(1'b0, 32'h00, 32'hFF, 1'b0, "freeze2");

        // Channel 0 conflict for three cycles, then clr together with a conflict.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h01, 32'h01, 1'b0, "conf3");
        cycle(1'b1, 32'h01, 32'h01, 1'b1, "clr_conf");
        cycle(1'b0, 32'h00, 32'h00, 1'b0, "idle");

        // Saturation run on the narrow counters.
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h11, 32'h11, 1'b0, "sat");
        cycle(1'b0, 32'h00, 32'h00, 1'b1, "clr_dis");
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hFF, 32'hFF, 1'b0, "allconf");

        for (int i = 0; i < 150; i++) random_cycle(1'b0, "rand");
        mid_reset();
        cycle(1'b1, 32'h3C, 32'h03, 1'b0, "post_rst");
        for (int i = 0; i < 150; i++) random_cycle(1'b1, "rand_nc");
        for (int i = 0; i < 300; i++) random_cycle(1'b0, "rand2");
        for (int i = 0; i < 300; i++) cycle(1'b1, $urandom, $urandom, 1'b0, "long");
        mid_reset();
        for (int i = 0; i < 50; i++) random_cycle(1'b0, "rand3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sr_bank.md
SR_BANK -- requirements
Module: sr_bank

Interface
REQ-001 Parameter N, default 8: number of independent set/reset channels, 1..32.
REQ-002 Parameter PRIO, default 0: conflict resolution; 0 = reset dominant, 1 = set dominant, 2 = hold.
REQ-003 Parameter INIT, default {N{1'b0}}: per-channel q value after reset.
REQ-004 Parameter CW, default 8: width of conflict counter, 1..16.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 e  input  1  global enable; 0 freezes all state.
REQ-008 s  input  N  per-channel set request.
REQ-009 r  input  N  per-channel reset request.
REQ-010 clr  input  1  synchronous clear of err and cnt.
REQ-011 q  output  N  registered channel state.
REQ-012 qn  output  N  bitwise complement of q, always.
REQ-013 conf  output  N  registered per-channel conflict flags from the previous enabled cycle.
REQ-014 err  output  1  sticky conflict flag.
REQ-015 cnt  output  CW  saturating count of conflict cycles.

Function
REQ-016 All outputs SHALL be registered; one-cycle latency from s/r/e/clr to q/conf/err/cnt.
REQ-017 With e=0 at a rising edge: q, conf, err and cnt SHALL hold, except clr, which SHALL still act.
REQ-018 With e=1, per channel i: s=0,r=0 -> hold; s=0,r=1 -> q[i]=0; s=1,r=0 -> q[i]=1.
REQ-019 With e=1 and s[i]=r[i]=1 (conflict): q[i] SHALL follow PRIO (0 -> 0, 1 -> 1, 2 -> hold); q SHALL never be X.
REQ-020 conf[i] SHALL be 1 for the cycle after a conflict on channel i with e=1, else 0; with e=0, conf SHALL hold.
REQ-021 A conflict cycle SHALL mean e=1 with at least one conf bit set; err SHALL set on it and stay set until clr or rst.
REQ-022 cnt SHALL increment by 1 per conflict cycle, regardless of how many channels conflict.
REQ-023 cnt SHALL saturate at 2^CW-1 with no wrap.
REQ-024 clr=1 SHALL force err=0 and cnt=0 next cycle and take priority over a same-cycle conflict, which is not counted; q and conf still update normally.
REQ-025 Channels SHALL be fully independent; no channel's s/r SHALL affect another channel's q.
REQ-026 PRIO outside 0..2 SHALL behave as 0.

Reset
REQ-027 rst=1 SHALL immediately, without clock, force q=INIT, qn=~INIT, conf=0, err=0, cnt=0.
REQ-028 While rst=1, all inputs SHALL be ignored; the first update SHALL occur on the first rising edge after rst deasserts.
REQ-029 rst asserted mid-operation SHALL discard any in-flight request; no partial update SHALL be visible.

Configuration
REQ-030 Macro SR_BANK_TOGGLE_EN: when defined, s[i]=r[i]=1 with e=1 SHALL toggle q[i] (JK behaviour), PRIO SHALL be ignored, and the case SHALL not count as a conflict; conf, err and cnt SHALL stay 0.
REQ-031 Without SR_BANK_TOGGLE_EN, conflict handling SHALL follow REQ-019 to REQ-024.

Verification
REQ-032 N=8, INIT=8'hA5, rst pulse between edges -> q=8'hA5, qn=8'h5A, err=0, cnt=0 immediately, without a clock edge.
REQ-033 e=1, s=8'h0F, r=8'hF0 from q=0 -> q=8'h0F after one edge; then e=0 with s=8'hFF -> q remains 8'h0F.
REQ-034 PRIO=1, e=1, s=r=8'h01 for 3 cycles -> q[0]=1, conf=8'h01, err=1, cnt=3; apply clr together with a conflict -> err=0, cnt=0.
REQ-035 CW=2, 5 consecutive conflict cycles -> cnt sequence 1,2,3,3,3, no wrap.
REQ-036 SR_BANK_TOGGLE_EN defined, q[0]=0, s=r=1 for 4 cycles -> q[0] sequence 1,0,1,0; err=0, cnt=0.
REQ-037 rst asserted mid-burst during conflicts, then deasserted -> all outputs at reset values; first update on the next edge.
